// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings and line/baud constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_TX_IDLE   = 3'd0,
        ST_TX_START  = 3'd1,
        ST_TX_DATA   = 3'd2,
        ST_TX_PARITY = 3'd3,
        ST_TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DIV_115200 = 434;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clk_50 cycles per UART bit and pulses bit_end on the last one.
module uart_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk_50,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic bit_end
);
    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] baud_cnt;

    assign bit_end = run && (baud_cnt == CNT_LAST);

    // Held at zero while idle so a restart always begins a full bit period.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (restart || !run || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready byte input and back-to-back framing.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
//
//   state        | meaning
//   ST_TX_IDLE   | line high, ready for a word
//   ST_TX_START  | start bit (low)
//   ST_TX_DATA   | data bits, LSB first
//   ST_TX_PARITY | parity bit (UART_TX_PARITY_EN builds only)
//   ST_TX_STOP   | stop bit(s) (high); last bit_end may accept the next word
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_DIV_115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_50,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_txd,
    output logic                 busy,
    output logic [15:0]          frame_count
);
    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 bit_end;
    logic                 frame_done;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign frame_done = (state == ST_TX_STOP) && (stop_idx == LAST_STOP) && bit_end;
    assign tx_ready   = !reset && ((state == ST_TX_IDLE) || frame_done);
    assign accept     = tx_valid && tx_ready;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk_50  (clk_50),
        .reset   (reset),
        .restart (accept),
        .run     (state != ST_TX_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state       <= ST_TX_IDLE;
            uart_txd    <= UART_IDLE_LEVEL;
            busy        <= 1'b0;
            frame_count <= 16'd0;
            shift_reg   <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            // An accept on the last stop bit overrides the return to IDLE.
            if (accept) begin
                state      <= ST_TX_START;
                uart_txd   <= ~UART_IDLE_LEVEL;
                busy       <= 1'b1;
                shift_reg  <= tx_data;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
            end else if (bit_end) begin
                case (state)
                    ST_TX_START: begin
                        state     <= ST_TX_DATA;
                        uart_txd  <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                    end
                    ST_TX_DATA: begin
                        if (bit_idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                            state    <= ST_TX_PARITY;
                            uart_txd <= parity_bit;
`else
                            state    <= ST_TX_STOP;
                            uart_txd <= UART_IDLE_LEVEL;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            uart_txd  <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_TX_PARITY: begin
                        state    <= ST_TX_STOP;
                        uart_txd <= UART_IDLE_LEVEL;
                        stop_idx <= 1'b0;
                    end
`endif
                    ST_TX_STOP: begin
                        if (stop_idx == LAST_STOP) begin
                            state    <= ST_TX_IDLE;
                            uart_txd <= UART_IDLE_LEVEL;
                            busy     <= 1'b0;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_TX_IDLE;
                        uart_txd <= UART_IDLE_LEVEL;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at BAUD_DIV=4; honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_param;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LEN1 = (1 + 8 + PB + 1) * BD;
    localparam int LEN2 = (1 + 8 + PB + 2) * BD;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic [7:0]  tx_data;
    logic        tx_valid_a, tx_valid_b;
    logic        tx_ready_a, tx_ready_b;
    logic        txd_a, txd_b;
    logic        busy_a, busy_b;
    logic [15:0] count_a, count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk_50 = ~clk_50;

    uart_tx_param #(
        .BAUD_DIV (BD), .DATA_BITS (8), .STOP_BITS (1), .PARITY_ODD (0)
    ) dut (
        .clk_50 (clk_50), .reset (reset), .tx_data (tx_data), .tx_valid (tx_valid_a),
        .tx_ready (tx_ready_a), .uart_txd (txd_a), .busy (busy_a), .frame_count (count_a)
    );

    uart_tx_param #(
        .BAUD_DIV (BD), .DATA_BITS (8), .STOP_BITS (2), .PARITY_ODD (1)
    ) dut2 (
        .clk_50 (clk_50), .reset (reset), .tx_data (tx_data), .tx_valid (tx_valid_b),
        .tx_ready (tx_ready_b), .uart_txd (txd_b), .busy (busy_b), .frame_count (count_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle line levels, index 0 = first start-bit cycle.
    function automatic logic [127:0] build_line(input logic [7:0] d, input int stops, input logic podd);
        logic [127:0] l;
        int p;
        l = '0;
        p = 0;
        for (int c = 0; c < BD; c++) begin l[p] = 1'b0; p++; end
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < BD; c++) begin l[p] = d[b]; p++; end
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < BD; c++) begin l[p] = (^d) ^ podd; p++; end
`else
        if (podd) l[p] = 1'b0;
`endif
        for (int c = 0; c < stops * BD; c++) begin l[p] = 1'b1; p++; end
        return l;
    endfunction

    // Starts at #1 after an edge; returns at #1 after the edge following the frame.
    task automatic send_capture(input int sel, input logic [7:0] d, input logic [7:0] d_after,
                                input int ncyc, output logic [127:0] line, output int busy_cnt);
        line = '0;
        busy_cnt = 0;
        check("ready_before_send", (sel != 0) ? tx_ready_b : tx_ready_a, 1'b1);
        tx_data = d;
        if (sel != 0) tx_valid_b = 1'b1; else tx_valid_a = 1'b1;
        @(posedge clk_50); #1;
        tx_data = d_after;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            line[i] = (sel != 0) ? txd_b : txd_a;
            busy_cnt += int'((sel != 0) ? busy_b : busy_a);
            @(posedge clk_50); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] line;
        int           bc;
        int           rdy_idx;
        int           rdy_n;

        reset = 1'b1;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk_50);
        #1;
        check("rst_txd",   txd_a, 1'b1);
        check("rst_busy",  busy_a, 1'b0);
        check("rst_count", count_a, 16'd0);
        check("rst_ready", tx_ready_a, 1'b0);
        reset = 1'b0;
        @(posedge clk_50); #1;

        // Abort during data bit 3 of 0xA3 (bit 3 = 0, cycles 16..19 of the frame).
        check("abort_ready", tx_ready_a, 1'b1);
        tx_data = 8'hA3;
        tx_valid_a = 1'b1;
        @(posedge clk_50); #1;
        tx_valid_a = 1'b0;
        repeat (17) @(posedge clk_50);
        #1;
        check("abort_pre_txd",  txd_a, 1'b0);
        check("abort_pre_busy", busy_a, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_txd",   txd_a, 1'b1);
        check("abort_busy",  busy_a, 1'b0);
        check("abort_count", count_a, 16'd0);
        @(posedge clk_50); #1;
        reset = 1'b0;
        @(posedge clk_50); #1;

        // 0x55 after the abort.
        send_capture(0, 8'h55, 8'h55, LEN1, line, bc);
        check("f55_line",  line, build_line(8'h55, 1, 1'b0));
`ifndef UART_TX_PARITY_EN
        check("f55_hand",  line, 128'hF0F0F0F0F0);
`endif
        check("f55_busy",  bc, LEN1);
        check("f55_count", count_a, 16'd1);
        check("f55_idle_txd",  txd_a, 1'b1);
        check("f55_idle_busy", busy_a, 1'b0);

        // tx_data changed right after accept must not corrupt the frame.
        send_capture(0, 8'h3C, 8'hFF, LEN1, line, bc);
        check("f3c_line",  line, build_line(8'h3C, 1, 1'b0));
        check("f3c_count", count_a, 16'd2);

        // Back-to-back 0x00 then 0xFF with tx_valid held.
        tx_data = 8'h00;
        tx_valid_a = 1'b1;
        @(posedge clk_50); #1;
        tx_data = 8'hFF;
        line = '0;
        rdy_idx = -1;
        rdy_n = 0;
        for (int i = 0; i < 2 * LEN1; i++) begin
            if (rdy_idx >= 0) tx_valid_a = 1'b0;
            line[i] = txd_a;
            if (tx_ready_a && i < 2 * LEN1 - 1) begin
                rdy_n++;
                if (rdy_idx < 0) rdy_idx = i;
            end
            @(posedge clk_50); #1;
        end
        tx_valid_a = 1'b0;
        check("b2b_line", line, build_line(8'h00, 1, 1'b0) | (build_line(8'hFF, 1, 1'b0) << LEN1));
        check("b2b_ready_idx", rdy_idx, LEN1 - 1);
        check("b2b_ready_pulses", rdy_n, 1);
        check("b2b_count", count_a, 16'd4);
        check("b2b_idle_txd", txd_a, 1'b1);

        // Two stop bits on dut2.
        send_capture(1, 8'h80, 8'h80, LEN2, line, bc);
        check("stop2_line",  line, build_line(8'h80, 2, 1'b1));
`ifndef UART_TX_PARITY_EN
        check("stop2_hand",  line, 128'hFFF00000000);
`endif
        check("stop2_busy",  bc, LEN2);
        check("stop2_count", count_b, 16'd1);
        check("stop2_idle_txd", txd_b, 1'b1);

`ifdef UART_TX_PARITY_EN
        send_capture(0, 8'h07, 8'h00, LEN1, line, bc);
        check("par_even_line", line, build_line(8'h07, 1, 1'b0));
        check("par_even_bit",  line[9 * BD + 1], 1'b1);
        check("par_even_busy", bc, 44);
        send_capture(1, 8'h07, 8'h00, LEN2, line, bc);
        check("par_odd_line", line, build_line(8'h07, 2, 1'b1));
        check("par_odd_bit",  line[9 * BD + 1], 1'b0);
        check("par_odd_count", count_b, 16'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
